imm_pack: RTL and testbench

IMM_PACK -- requirements
Module: imm_pack

---
 rtl/imm_pack_pkg.sv | 42 ++++
 rtl/imm_pack_fmt.sv | 58 +++++
 rtl/imm_pack.sv | 79 +++++++
 tb/tb_imm_pack.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pack_pkg.sv
// Shared immediate-format encodings and pipeline bundle types for imm_pack.
// Ports: none (package only).
package imm_pack_pkg;

  // Immediate formats; encodings 101-111 are undefined.
  typedef enum logic [2:0] {
    SRC_I = 3'b000,
    SRC_S = 3'b001,
    SRC_B = 3'b010,
    SRC_J = 3'b011,
    SRC_U = 3'b100
  } imm_src_e;

  // Packed instruction word plus its error flags.
  typedef struct packed {
    logic [31:0] instr;
    logic        range_err;
    logic        align_err;
    logic        src_err;
  } pack_t;

  // Sign-extending immediate decoder; pack() is its inverse.
  function automatic logic [31:0] imm_decode(
    input imm_src_e    src,
    input logic [31:0] x
  );
    logic [31:0] r;
    r = '0;
    case (src)
      SRC_I: r = {{20{x[31]}}, x[31:20]};
      SRC_S: r = {{20{x[31]}}, x[31:25], x[11:7]};
      SRC_B: r = {{20{x[31]}}, x[7], x[30:25],
                  x[11:8], 1'b0};
      SRC_J: r = {{12{x[31]}}, x[19:12], x[20],
                  x[30:21], 1'b0};
      SRC_U: r = {x[31:12], 12'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_pack_fmt.sv
// Combinational immediate packer with range/alignment/format checks.
// Ports: src (format), imm (value), base (instr word) -> res (instr + flags).
module imm_pack_fmt
  import imm_pack_pkg::*;
(
  input  imm_src_e    src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output pack_t       res
);

  // High bits must be a pure sign extension of the top kept bit.
  logic is_ok;
  logic bs_ok;
  logic j_ok;

  assign is_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign bs_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_ok  = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    res       = '0;
    res.instr = base;
    case (src)
      SRC_I: begin
        res.instr[31:20] = imm[11:0];
        res.range_err    = ~is_ok;
      end
      SRC_S: begin
        res.instr[31:25] = imm[11:5];
        res.instr[11:7]  = imm[4:0];
        res.range_err    = ~is_ok;
      end
      SRC_B: begin
        res.instr[31]    = imm[12];
        res.instr[30:25] = imm[10:5];
        res.instr[11:8]  = imm[4:1];
        res.instr[7]     = imm[11];
        res.range_err    = ~bs_ok;
        res.align_err    = imm[0];
      end
      SRC_J: begin
        res.instr[31]    = imm[20];
        res.instr[30:21] = imm[10:1];
        res.instr[20]    = imm[11];
        res.instr[19:12] = imm[19:12];
        res.range_err    = ~j_ok;
        res.align_err    = imm[0];
      end
      SRC_U: begin
        res.instr[31:12] = imm[31:12];
        res.range_err    = |imm[11:0];
      end
      default: res.src_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer with saturating error counter.
// Ports: CLK/Reset, InValid/InReady/ImmSrc/Imm/Base in,
// OutValid/OutReady/Instr/RangeErr/AlignErr/SrcErr/ErrCount out.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      Base,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      Instr,
  output logic             RangeErr,
  output logic             AlignErr,
  output logic             SrcErr,
  output logic [CNT_W-1:0] ErrCount
);

  pack_t fmt_res;
  pack_t s1;
  logic  s1_valid;
  logic  s2_adv;
  logic  any_err;

  imm_pack_fmt u_fmt (
    .src  (imm_src_e'(ImmSrc)),
    .imm  (Imm),
    .base (Base),
    .res  (fmt_res)
  );

  assign s2_adv  = ~OutValid | OutReady;
  assign InReady = ~s1_valid | s2_adv;
  assign any_err = RangeErr | AlignErr | SrcErr;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) s1 <= fmt_res;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      Instr    <= '0;
      RangeErr <= 1'b0;
      AlignErr <= 1'b0;
      SrcErr   <= 1'b0;
    end else if (s2_adv) begin
      OutValid <= s1_valid;
      if (s1_valid) begin
        Instr    <= s1.instr;
        RangeErr <= s1.range_err;
        AlignErr <= s1.align_err;
        SrcErr   <= s1.src_err;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ErrCount <= '0;
    end else if (OutValid && OutReady && any_err
                 && ErrCount != '1) begin
      ErrCount <= ErrCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed vectors, backpressure,
// reset flush and a pack-then-decode round trip on random requests.
module tb_imm_pack;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [2:0]  ImmSrc;
  logic [31:0] Imm;
  logic [31:0] Base;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Instr;
  logic        RangeErr;
  logic        AlignErr;
  logic        SrcErr;
  logic [15:0] ErrCount;

  imm_pack #(.CNT_W(16)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .ImmSrc   (ImmSrc),
    .Imm      (Imm),
    .Base     (Base),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Instr    (Instr),
    .RangeErr (RangeErr),
    .AlignErr (AlignErr),
    .SrcErr   (SrcErr),
    .ErrCount (ErrCount)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_done = 0;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [2:0]  flags;
    bit          rt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t e_out;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference decoder.
  function automatic logic [31:0] dec(logic [2:0] s,
                                      logic [31:0] x);
    case (s)
      3'd0: dec = {{20{x[31]}}, x[31:20]};
      3'd1: dec = {{20{x[31]}}, x[31:25], x[11:7]};
      3'd2: dec = {{19{x[31]}}, x[31], x[7], x[30:25],
                   x[11:8], 1'b0};
      3'd3: dec = {{11{x[31]}}, x[31], x[19:12], x[20],
                   x[30:21], 1'b0};
      3'd4: dec = {x[31:12], 12'b0};
      default: dec = 32'hdead_beef;
    endcase
  endfunction

  // Scoreboard: record accepts, compare deliveries in order.
  always @(negedge CLK) begin
    if (!Reset && InValid && InReady) sb.push_back(cur);
    if (!Reset && OutValid && OutReady) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e_out = sb.pop_front();
        if (e_out.rt)
          check("roundtrip", dec(e_out.src, Instr), e_out.imm);
        else
          check("instr", Instr, e_out.instr);
        check("flags", {29'b0, RangeErr, AlignErr, SrcErr},
              {29'b0, e_out.flags});
      end
    end
  end

  task automatic send(logic [2:0] s, logic [31:0] i,
                      logic [31:0] b, logic [31:0] ei,
                      logic [2:0] ef, bit rt);
    int k;
    ImmSrc  = s;
    Imm     = i;
    Base    = b;
    cur     = '{s, i, ei, ef, rt};
    InValid = 1'b1;
    for (k = 0; k < 1000; k++) begin
      @(negedge CLK);
      if (InReady) break;
    end
    if (k == 1000) check("send_timeout", 32'(k), 32'd0);
    @(posedge CLK);
    #1 InValid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge CLK);
      if (sb.size() == 0) break;
    end
    if (k == 500) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] held;
  logic [2:0]  rs;
  logic [31:0] r;
  logic [31:0] ri;

  initial begin
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    ImmSrc   = '0;
    Imm      = '0;
    Base     = '0;
    #12;
    check("rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_flags", {29'b0, RangeErr, AlignErr, SrcErr}, 32'd0);
    check("rst_errcount", {16'b0, ErrCount}, 32'd0);
    @(posedge CLK);
    #1 Reset = 1'b0;
    check("rst_inready", {31'b0, InReady}, 32'd1);

    // Latency: accepted at edge k, visible after edge k+1.
    ImmSrc  = 3'd0;
    Imm     = 32'hffff_ffff;
    Base    = 32'h0000_0013;
    cur     = '{3'd0, 32'hffff_ffff, 32'hfff0_0013, 3'b000, 1'b0};
    InValid = 1'b1;
    @(posedge CLK);
    #1 InValid = 1'b0;
    check("lat_cycle1", {31'b0, OutValid}, 32'd0);
    @(posedge CLK);
    #1;
    check("lat_cycle2", {31'b0, OutValid}, 32'd1);
    check("lat_instr", Instr, 32'hfff0_0013);

    send(3'd1, 32'd8, 32'h2023, 32'h0000_2423, 3'b000, 0);
    send(3'd2, 32'hffff_fffc, 32'h63, 32'hfe00_0ee3, 3'b000, 0);
    send(3'd4, 32'h1234_5000, 32'h37, 32'h1234_5037, 3'b000, 0);
    send(3'd4, 32'h1234_5001, 32'h37, 32'h1234_5037, 3'b100, 0);
    send(3'd2, 32'd3, 32'h63, 32'h0000_0163, 3'b010, 0);
    send(3'd7, 32'h1234, 32'h63, 32'h0000_0063, 3'b001, 0);
    drain();
    check("errcount_3", {16'b0, ErrCount}, 32'd3);

    // Backpressure: two accepted, then stall holds outputs.
    OutReady = 1'b0;
    send(3'd0, 32'd5, 32'h13, 32'h0050_0013, 3'b000, 0);
    send(3'd3, 32'h800, 32'h6f, 32'h0010_006f, 3'b000, 0);
    check("bp_inready", {31'b0, InReady}, 32'd0);
    check("bp_outvalid", {31'b0, OutValid}, 32'd1);
    held = Instr;
    check("bp_head", held, 32'h0050_0013);
    @(posedge CLK);
    #1;
    check("bp_hold_instr", Instr, held);
    check("bp_hold_valid", {31'b0, OutValid}, 32'd1);
    OutReady = 1'b1;
    send(3'd4, 32'hffff_f000, 32'h37, 32'hffff_f037, 3'b000, 0);
    send(3'd1, 32'hffff_ffff, 32'h2023, 32'hfe00_2fa3, 3'b000, 0);
    drain();
    check("errcount_hold", {16'b0, ErrCount}, 32'd3);

    // Reset with both stages full.
    OutReady = 1'b0;
    send(3'd0, 32'd1, 32'h13, 32'h0010_0013, 3'b000, 0);
    send(3'd7, 32'd0, 32'h13, 32'h0000_0013, 3'b001, 0);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("mid_rst_errcount", {16'b0, ErrCount}, 32'd0);
    check("mid_rst_instr", Instr, 32'd0);
    sb.delete();
    @(posedge CLK);
    #1 Reset = 1'b0;
    OutReady = 1'b1;
    check("post_rst_inready", {31'b0, InReady}, 32'd1);

    // Random error-free round trip with random backpressure.
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          rs = 3'($urandom_range(0, 4));
          r  = $urandom;
          case (rs)
            3'd0, 3'd1: ri = {{20{r[11]}}, r[11:0]};
            3'd2: ri = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3: ri = {{11{r[20]}}, r[20:1], 1'b0};
            default: ri = {r[31:12], 12'b0};
          endcase
          send(rs, ri, $urandom, 32'd0, 3'b000, 1);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK);
          #1 OutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OutReady = 1'b1;
    drain();
    check("rnd_errcount", {16'b0, ErrCount}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
